// File: rtl/gb_pool_rd_responder.sv
// ---------------------------------------------------------------------------
// gb_pool_rd_responder
//
// Global-buffer-side responder for the pooling unit's psum read channel.
// POOL issues word addresses relative to the current feature group. Each one
// is offset by the group base and turned into a 1-cycle-latency SRAM read.
// The returned 16-psum words are buffered and handed back to POOL over a
// val/rdy handshake. When every word of the group has been delivered, the
// block pulses done towards the CCU.
//
// Handshake semantics (both channels): a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge. A valid request is
// held stable by its producer until it is accepted. GBPOOL_req_rdy and
// GBPOOL_val are driven only from registers, so neither depends
// combinationally on POOLGB_req_val or POOLGB_rdy.
//
// Optional feature: define POOL_RD_STAT_EN to add the two statistics
// counters stat_word_cnt and stat_stall_cnt.
//
// Ports
//   Clk, rst_n       clock, asynchronous active-low reset
//   CCUPOOL_start    one-cycle start pulse; CFG_* sampled with it (IDLE only)
//   CFG_base_addr    GB base address of the feature group
//   CFG_num_word     number of words in the group (0 -> done at once)
//   POOLGB_req_val   POOL read request valid
//   POOLGB_addr      POOL-relative word address
//   GBPOOL_req_rdy   request accepted when high together with req_val
//   GBPOOL_val       response word valid
//   GBPOOL_data      response word, lane j at [PSUM_WIDTH*j +: PSUM_WIDTH]
//   POOLGB_rdy       POOL accepts the response word
//   sram_rd_en       SRAM read enable (high exactly on accepted requests)
//   sram_addr        SRAM word address (0 when no read)
//   sram_rd_data     SRAM data, valid the cycle after sram_rd_en
//   POOLCCU_done     one-cycle pulse, group fully delivered
//   dbg_state        FSM state: 0 IDLE, 1 RUN, 2 DONE
//   stat_word_cnt    (POOL_RD_STAT_EN) responses delivered since reset
//   stat_stall_cnt   (POOL_RD_STAT_EN) cycles with val=1 and rdy=0
// ---------------------------------------------------------------------------
module gb_pool_rd_responder #(
   parameter int PSUM_WIDTH = 20,
   parameter int NUM_PSUM   = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 12,
   parameter int FIFO_DEPTH = 3
) (
   input  logic                           Clk,
   input  logic                           rst_n,
   input  logic                           CCUPOOL_start,
   input  logic [ADDR_WIDTH-1:0]          CFG_base_addr,
   input  logic [CNT_WIDTH-1:0]           CFG_num_word,
   input  logic                           POOLGB_req_val,
   input  logic [ADDR_WIDTH-1:0]          POOLGB_addr,
   output logic                           GBPOOL_req_rdy,
   output logic                           GBPOOL_val,
   output logic [NUM_PSUM*PSUM_WIDTH-1:0] GBPOOL_data,
   input  logic                           POOLGB_rdy,
   output logic                           sram_rd_en,
   output logic [ADDR_WIDTH-1:0]          sram_addr,
   input  logic [NUM_PSUM*PSUM_WIDTH-1:0] sram_rd_data,
   output logic                           POOLCCU_done,
   output logic [1:0]                     dbg_state
`ifdef POOL_RD_STAT_EN
   ,
   output logic [31:0]                    stat_word_cnt,
   output logic [31:0]                    stat_stall_cnt
`endif
);

   localparam int DATA_W = NUM_PSUM * PSUM_WIDTH;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Occupancy counts FIFO entries plus the in-flight read, so it must hold
   // FIFO_DEPTH + 1.
   localparam int OCC_W  = $clog2(FIFO_DEPTH + 2);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_WIDTH-1:0]  num_word_q, num_word_d;
   logic [CNT_WIDTH-1:0]  req_cnt_q, req_cnt_d;
   logic [CNT_WIDTH-1:0]  rsp_cnt_q, rsp_cnt_d;
   logic                  inflight_q, inflight_d;

   logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]     mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      fifo_cnt_q, fifo_cnt_d;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   logic [OCC_W-1:0]      occ;
   logic                  req_rdy;
   logic                  req_fire;
   logic                  rsp_val;
   logic                  pop;
   logic                  push;
   logic [ADDR_WIDTH-1:0] rd_addr;

   always_comb begin
      occ      = fifo_cnt_q + OCC_W'(inflight_q);
      // A new read is taken only while a slot is free for it, counting the
      // read already on its way back from the SRAM. This guarantees the push
      // in the following cycle always finds space.
      req_rdy  = (state_q == ST_RUN) && (req_cnt_q < num_word_q) &&
                 (occ < OCC_MAX);
      req_fire = POOLGB_req_val && req_rdy;
      // Base offset wraps modulo 2^ADDR_WIDTH by truncation.
      rd_addr  = base_q + POOLGB_addr;
      rsp_val  = (fifo_cnt_q != '0);
      pop      = rsp_val && POOLGB_rdy;
      // SRAM data returns exactly one cycle after the read enable.
      push     = inflight_q;
   end

   // ------------------------------------------------------------------------
   // FSM and group counters
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_word_d = num_word_q;
      req_cnt_d  = req_cnt_q;
      rsp_cnt_d  = rsp_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (CCUPOOL_start) begin
               base_d     = CFG_base_addr;
               num_word_d = CFG_num_word;
               req_cnt_d  = '0;
               rsp_cnt_d  = '0;
               state_d    = (CFG_num_word == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (req_fire) begin
               req_cnt_d = req_cnt_q + CNT_WIDTH'(1);
            end
            if (pop) begin
               rsp_cnt_d = rsp_cnt_q + CNT_WIDTH'(1);
            end
            // Includes a handshake completing in this very cycle.
            if (rsp_cnt_d == num_word_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Response FIFO (circular buffer, head read straight from registers)
   // ------------------------------------------------------------------------
   always_comb begin
      inflight_d = req_fire;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = sram_rd_data;
         wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + OCC_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - OCC_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         num_word_q <= '0;
         req_cnt_q  <= '0;
         rsp_cnt_q  <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_word_q <= num_word_d;
         req_cnt_q  <= req_cnt_d;
         rsp_cnt_q  <= rsp_cnt_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign GBPOOL_req_rdy = req_rdy;
   assign sram_rd_en     = req_fire;
   assign sram_addr      = req_fire ? rd_addr : '0;
   assign GBPOOL_val     = rsp_val;
   assign GBPOOL_data    = rsp_val ? mem_q[rd_ptr_q] : '0;
   assign POOLCCU_done   = (state_q == ST_DONE);
   assign dbg_state      = state_q;

`ifdef POOL_RD_STAT_EN
   // ------------------------------------------------------------------------
   // Statistics: saturating counters, never cleared except by reset
   // ------------------------------------------------------------------------
   logic [31:0] stat_word_cnt_q, stat_word_cnt_d;
   logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

   always_comb begin
      stat_word_cnt_d  = stat_word_cnt_q;
      stat_stall_cnt_d = stat_stall_cnt_q;
      if (pop && (stat_word_cnt_q != '1)) begin
         stat_word_cnt_d = stat_word_cnt_q + 32'd1;
      end
      if (rsp_val && !POOLGB_rdy && (stat_stall_cnt_q != '1)) begin
         stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_word_cnt_q  <= '0;
         stat_stall_cnt_q <= '0;
      end else begin
         stat_word_cnt_q  <= stat_word_cnt_d;
         stat_stall_cnt_q <= stat_stall_cnt_d;
      end
   end

   assign stat_word_cnt  = stat_word_cnt_q;
   assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule

// File: tb/tb_gb_pool_rd_responder.sv
// ---------------------------------------------------------------------------
// tb_gb_pool_rd_responder
//
// Drives feature groups into gb_pool_rd_responder and checks every cycle
// against a transaction-level reference: each accepted request becomes one
// expected response word (looked up in the SRAM image at the wrapped
// address), available two cycles later, delivered in order. The bench also
// plays the SRAM, returning data the cycle after a read enable and random
// junk otherwise.
// ---------------------------------------------------------------------------
module tb_gb_pool_rd_responder;

   localparam int PW = 20;
   localparam int NP = 16;
   localparam int AW = 10;
   localparam int CW = 12;
   localparam int DW = PW * NP;
   localparam int DEPTH = 3;
   localparam int BUDGET = 2000;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   // ------------------------------------------------------------------------
   // Clock / reset and DUT
   // ------------------------------------------------------------------------
   logic          Clk = 1'b0;
   logic          rst_n;
   logic          CCUPOOL_start;
   logic [AW-1:0] CFG_base_addr;
   logic [CW-1:0] CFG_num_word;
   logic          POOLGB_req_val;
   logic [AW-1:0] POOLGB_addr;
   logic          GBPOOL_req_rdy;
   logic          GBPOOL_val;
   logic [DW-1:0] GBPOOL_data;
   logic          POOLGB_rdy;
   logic          sram_rd_en;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_rd_data;
   logic          POOLCCU_done;
   logic [1:0]    dbg_state;
`ifdef POOL_RD_STAT_EN
   logic [31:0]   stat_word_cnt;
   logic [31:0]   stat_stall_cnt;
`endif

   always #5 Clk = ~Clk;

   gb_pool_rd_responder #(
      .PSUM_WIDTH (PW),
      .NUM_PSUM   (NP),
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .Clk            (Clk),
      .rst_n          (rst_n),
      .CCUPOOL_start  (CCUPOOL_start),
      .CFG_base_addr  (CFG_base_addr),
      .CFG_num_word   (CFG_num_word),
      .POOLGB_req_val (POOLGB_req_val),
      .POOLGB_addr    (POOLGB_addr),
      .GBPOOL_req_rdy (GBPOOL_req_rdy),
      .GBPOOL_val     (GBPOOL_val),
      .GBPOOL_data    (GBPOOL_data),
      .POOLGB_rdy     (POOLGB_rdy),
      .sram_rd_en     (sram_rd_en),
      .sram_addr      (sram_addr),
      .sram_rd_data   (sram_rd_data),
      .POOLCCU_done   (POOLCCU_done),
      .dbg_state      (dbg_state)
`ifdef POOL_RD_STAT_EN
      ,
      .stat_word_cnt  (stat_word_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   // ------------------------------------------------------------------------
   // Scoreboard / reference model state
   // ------------------------------------------------------------------------
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;

   logic [DW-1:0] sram_img [1024];
   logic [DW-1:0] exp_q[$];     // expected response words, in order
   int            avail_q[$];   // cycle from which each word may be valid

   int            m_phase;
   int            m_base;
   int            m_num;
   int            m_issued;
   int            m_delivered;
   int            m_words;
   int            m_stalls;

   logic          pend_en;
   logic [AW-1:0] pend_addr;

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int j = 0; j < NP; j++) begin
         w[PW*j +: PW] = PW'($urandom);
      end
      return w;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      avail_q.delete();
      m_phase     = M_IDLE;
      m_base      = 0;
      m_num       = 0;
      m_issued    = 0;
      m_delivered = 0;
      m_words     = 0;
      m_stalls    = 0;
      pend_en     = 1'b0;
      pend_addr   = '0;
   endtask

   // ------------------------------------------------------------------------
   // One clock cycle: check outputs mid-cycle, advance the model, then play
   // the SRAM for the next cycle. Inputs for the cycle are set by the caller
   // before calling.
   // ------------------------------------------------------------------------
   task automatic tick();
      logic          exp_rdy;
      logic          fire;
      logic          exp_val;
      logic          pop;
      logic [DW-1:0] exp_data;
      int            exp_addr;

      @(negedge Clk);
      exp_rdy  = (m_phase == M_RUN) && (m_issued < m_num) &&
                 (exp_q.size() < DEPTH);
      fire     = POOLGB_req_val && exp_rdy;
      exp_val  = (exp_q.size() > 0) && (avail_q[0] <= cyc);
      exp_data = exp_val ? exp_q[0] : '0;
      exp_addr = (m_base + int'(POOLGB_addr)) % 1024;

      check("req_rdy", DW'(GBPOOL_req_rdy), DW'(exp_rdy));
      check("sram_rd_en", DW'(sram_rd_en), DW'(fire));
      if (fire) begin
         check("sram_addr", DW'(sram_addr), DW'(exp_addr));
      end
      check("rsp_val", DW'(GBPOOL_val), DW'(exp_val));
      check("rsp_data", GBPOOL_data, exp_data);
      check("done", DW'(POOLCCU_done), DW'(m_phase == M_DONE));

      pend_en   = sram_rd_en;
      pend_addr = sram_addr;

      pop = exp_val && POOLGB_rdy;
      if (exp_val && !POOLGB_rdy) m_stalls++;
      if (pop) begin
         void'(exp_q.pop_front());
         void'(avail_q.pop_front());
         m_delivered++;
         m_words++;
      end
      if (fire) begin
         exp_q.push_back(sram_img[exp_addr]);
         avail_q.push_back(cyc + 2);
         m_issued++;
      end

      case (m_phase)
         M_IDLE: begin
            if (CCUPOOL_start) begin
               m_base      = int'(CFG_base_addr);
               m_num       = int'(CFG_num_word);
               m_issued    = 0;
               m_delivered = 0;
               m_phase     = (m_num == 0) ? M_DONE : M_RUN;
            end
         end
         M_RUN:   if (m_delivered == m_num) m_phase = M_DONE;
         default: m_phase = M_IDLE;
      endcase

      @(posedge Clk);
      cyc++;
      #1;
      sram_rd_data = pend_en ? sram_img[pend_addr] : rand_word();
   endtask

   // ------------------------------------------------------------------------
   // Driver: run one feature group to completion.
   //   mode 0 streaming, 1 backpressure window, 2 random, 3 ignored start
   // ------------------------------------------------------------------------
   task automatic run_group(input int base, input int num, input int mode,
                            input int addr_start);
      int k;
      CFG_base_addr  = AW'(base);
      CFG_num_word   = CW'(num);
      CCUPOOL_start  = 1'b1;
      POOLGB_req_val = 1'b0;
      POOLGB_rdy     = 1'b1;
      tick();
      CCUPOOL_start = 1'b0;
      k = 0;
      while (m_phase != M_IDLE && k < BUDGET) begin
         CCUPOOL_start  = 1'b0;
         POOLGB_req_val = 1'b1;
         POOLGB_rdy     = 1'b1;
         POOLGB_addr    = AW'(addr_start + m_issued);
         case (mode)
            1: POOLGB_rdy = !(k >= 3 && k <= 7);
            2: begin
               POOLGB_req_val = ($urandom_range(0, 3) != 0);
               POOLGB_rdy     = ($urandom_range(0, 2) != 0);
               POOLGB_addr    = AW'($urandom);
            end
            3: begin
               if (k == 3) begin
                  CCUPOOL_start = 1'b1;
                  CFG_base_addr = AW'(base + 333);
                  CFG_num_word  = CW'(num + 5);
               end
            end
            default: ;
         endcase
         tick();
         k++;
      end
      CCUPOOL_start  = 1'b0;
      POOLGB_req_val = 1'b0;
      if (k >= BUDGET) check("group_timeout", DW'(1), DW'(0));
   endtask

   task automatic apply_reset();
      POOLGB_req_val = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_req_rdy", DW'(GBPOOL_req_rdy), '0);
      check("rst_val", DW'(GBPOOL_val), '0);
      check("rst_data", GBPOOL_data, '0);
      check("rst_rd_en", DW'(sram_rd_en), '0);
      check("rst_sram_addr", DW'(sram_addr), '0);
      check("rst_done", DW'(POOLCCU_done), '0);
      model_reset();
      POOLGB_req_val = 1'b0;
      CCUPOOL_start  = 1'b0;
      repeat (2) @(posedge Clk);
      cyc += 2;
      #1;
      rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   initial begin
      for (int i = 0; i < 1024; i++) sram_img[i] = rand_word();
      CCUPOOL_start  = 1'b0;
      CFG_base_addr  = '0;
      CFG_num_word   = '0;
      POOLGB_addr    = '0;
      POOLGB_rdy     = 1'b1;
      sram_rd_data   = rand_word();

      // Power-on reset
      apply_reset();
      tick();
      check("idle_state", DW'(dbg_state), DW'(0));

      // Streaming: base 100, addresses 0..7
      run_group(100, 8, 0, 0);

      // Backpressure window of 5 cycles, from a clean reset for the stats
      apply_reset();
      tick();
      run_group(300, 8, 1, 0);
`ifdef POOL_RD_STAT_EN
      check("stat_words", DW'(stat_word_cnt), DW'(8));
      check("stat_stalls", DW'(stat_stall_cnt), DW'(5));
`endif

      // Address wrap: 1020 + 5 -> 1
      run_group(1020, 4, 0, 5);

      // Empty group: done without any SRAM read
      run_group(7, 0, 0, 0);

      // Start during RUN is ignored
      run_group(200, 6, 3, 0);
      tick();

      // Random groups
      for (int g = 0; g < 8; g++) begin
         run_group($urandom_range(0, 1023), $urandom_range(1, 20), 2, 0);
         repeat ($urandom_range(0, 2)) tick();
      end

`ifdef POOL_RD_STAT_EN
      check("stat_words_total", DW'(stat_word_cnt), DW'(m_words));
      check("stat_stalls_total", DW'(stat_stall_cnt), DW'(m_stalls));
`endif

      // Reset mid-transfer with two words buffered
      CFG_base_addr  = AW'(40);
      CFG_num_word   = CW'(6);
      CCUPOOL_start  = 1'b1;
      POOLGB_rdy     = 1'b0;
      tick();
      CCUPOOL_start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (exp_q.size() >= 2 && avail_q[1] <= cyc) break;
         POOLGB_req_val = (m_issued < 2);
         POOLGB_addr    = AW'(m_issued);
         tick();
      end
      check("mid_buffered", DW'(GBPOOL_val), DW'(1));
      apply_reset();
      POOLGB_req_val = 1'b1;
      POOLGB_rdy     = 1'b1;
      repeat (3) tick();
      check("post_rst_state", DW'(dbg_state), DW'(0));
      POOLGB_req_val = 1'b0;

      // The block still works after the mid-transfer reset
      run_group(512, 5, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gb_pool_rd_responder.md
Name: gb_pool_rd_responder

Overview:
- Global-buffer-side responder for the pooling unit's psum read channel.
- Accepts POOL read addresses, offsets them by a per-feature-group base, and issues 1-cycle-latency SRAM reads.
- Buffers the returned 16-psum words and delivers them to POOL over a val/rdy handshake.
- Counts words per feature group and pulses done when the group is fully delivered. Sits between the GB SRAM bank and POOL, sequenced by the CCU.

Parameters:
- PSUM_WIDTH, 20, bits per psum lane
- NUM_PSUM, 16, psum lanes per GB word
- ADDR_WIDTH, 10, GB word address width
- CNT_WIDTH, 12, word counter width
- FIFO_DEPTH, 3, response buffer entries (in-flight read counts as one entry)

Ports:
- Clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CCUPOOL_start  in  1  one-cycle pulse; load config and begin a feature group
- CFG_base_addr  in  ADDR_WIDTH  GB base address, sampled on start
- CFG_num_word  in  CNT_WIDTH  words in the group, sampled on start
- POOLGB_req_val  in  1  POOL read request valid
- POOLGB_addr  in  ADDR_WIDTH  POOL-relative word address
- GBPOOL_req_rdy  out  1  responder accepts request
- GBPOOL_val  out  1  response data valid
- GBPOOL_data  out  NUM_PSUM*PSUM_WIDTH  16 psums, lane j at [PSUM_WIDTH*j +: PSUM_WIDTH]
- POOLGB_rdy  in  1  POOL accepts response
- sram_rd_en  out  1  SRAM read enable
- sram_addr  out  ADDR_WIDTH  SRAM word address
- sram_rd_data  in  NUM_PSUM*PSUM_WIDTH  SRAM read data, valid the cycle after sram_rd_en
- POOLCCU_done  out  1  one-cycle pulse, group delivered

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO empty; inflight=0; counters=0. Outputs: GBPOOL_req_rdy=0, GBPOOL_val=0, GBPOOL_data=0, sram_rd_en=0, sram_addr=0, POOLCCU_done=0.
- FSM:
  - IDLE: CCUPOOL_start latches base, num_word, clears req_cnt/rsp_cnt -> RUN; if num_word==0 -> DONE instead.
  - RUN: when rsp_cnt reaches num_word (including the handshake this cycle) -> DONE.
  - DONE: POOLCCU_done=1 for exactly one cycle -> IDLE.
  - CCUPOOL_start outside IDLE is ignored.
- Request side:
  - GBPOOL_req_rdy = (state==RUN) && (req_cnt<num_word) && (inflight+fifo_cnt < FIFO_DEPTH). Registers only; no combinational path from POOLGB_rdy.
  - req_fire = POOLGB_req_val && GBPOOL_req_rdy.
  - On req_fire, in the same cycle: sram_rd_en=1, sram_addr=(base+POOLGB_addr) mod 2^ADDR_WIDTH (wraps, no error), req_cnt++, inflight set next cycle.
  - sram_rd_en=0 whenever req_fire=0; sram_addr is don't-care then.
- Read return: in the cycle after sram_rd_en, sram_rd_data is pushed into the FIFO at the clock edge. Space is guaranteed by the rdy rule.
- Response side:
  - GBPOOL_val = FIFO non-empty; GBPOOL_data = FIFO head, registered; 0 when empty.
  - Pop on GBPOOL_val && POOLGB_rdy; rsp_cnt++.
  - Push and pop in the same cycle keep fifo_cnt unchanged and preserve order.
- Latency: req_fire in cycle N -> GBPOOL_val in cycle N+2.
- Throughput: 1 word/cycle sustained with POOLGB_req_val and POOLGB_rdy held high.
- Backpressure: POOLGB_rdy=0 holds GBPOOL_data stable while GBPOOL_val=1. GBPOOL_req_rdy drops once 3 entries are occupied.
- POOLGB_addr and POOLGB_req_val are sampled only on req_fire.

Optional Feature:
- Macro: POOL_RD_STAT_EN.
- Defined: adds outputs stat_word_cnt (32b, total responses delivered since reset) and stat_stall_cnt (32b, cycles with GBPOOL_val=1 && POOLGB_rdy=0). Both saturate at all-ones and reset to 0 asynchronously.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-transfer: assert rst_n=0 with 2 words buffered -> all outputs 0 immediately; after release, state IDLE and GBPOOL_req_rdy=0.
- Streaming: start base=100, num_word=8, POOL requests addr 0..7 back-to-back with rdy=1 -> sram_addr 100..107 on consecutive cycles; GBPOOL_val from cycle 2 for 8 cycles; data lane j matches the SRAM model; done pulses once.
- Backpressure: POOLGB_rdy=0 for 5 cycles mid-stream -> GBPOOL_req_rdy falls after 3 occupied entries; data held stable; no loss or reordering after release.
- Wrap and zero: base=1020, addr 5 -> sram_addr=1. Start with num_word=0 -> done pulses the cycle after IDLE->DONE; no SRAM read.
- Ignored start: CCUPOOL_start pulsed during RUN with new config -> old group completes with original base/num_word.
- POOL_RD_STAT_EN: 8-word group with 5 stall cycles -> stat_word_cnt=8, stat_stall_cnt=5.
